// File: rtl/adc_spi_pkg.sv
// Shared constants, state encoding and frame helper for the AD7928-style SPI responder.
package adc_spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int ADDR_BITS  = 3;
    localparam int CNT_BITS   = 5;

    // Control word field positions within the 16-bit DIN frame
    localparam int WRITE_BIT  = 15;
    localparam int SEQ_BIT    = 14;
    localparam int ADD_HI     = 12;
    localparam int ADD_LO     = 10;
    localparam int PM_HI      = 9;
    localparam int PM_LO      = 8;
    localparam int SHADOW_BIT = 7;
    localparam int RANGE_BIT  = 5;
    localparam int CODING_BIT = 4;
    localparam int CTRL_LSB   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] data
    );
        return {1'b0, addr, data};
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer with rise/fall detection for one SPI pin.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_r;
    logic                   prev_r;

    // Chain resets low so a pin already low at reset release never looks like a fall
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_r <= {SYNC_STAGES{1'b0}};
            prev_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], pin};
            prev_r  <= chain_r[SYNC_STAGES-1];
        end
    end

    assign sync = chain_r[SYNC_STAGES-1];
    assign rise = chain_r[SYNC_STAGES-1] & ~prev_r;
    assign fall = ~chain_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC end of the SPI link: shifts out channel frames and decodes the DIN control word.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          adc_cs_n,
    input  logic                          adc_sclk,
    input  logic                          adc_din,
    input  logic [DATA_BITS*NUM_CH-1:0]   ch_data,
    output logic                          adc_dout,
    output logic                          adc_dout_oe,
    output logic [ADDR_BITS-1:0]          cur_addr,
    output logic [DATA_BITS-1:0]          ctrl_word,
    output logic                          ctrl_valid,
    output logic                          frame_err
);

    logic cs_sync_s, cs_rise_s, cs_fall_s;
    logic sclk_sync_s, sclk_rise_s, sclk_fall_s;
    logic din_sync_s, din_rise_s, din_fall_s;
    logic unused_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .reset(reset), .pin(adc_cs_n),
        .sync(cs_sync_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .reset(reset), .pin(adc_sclk),
        .sync(sclk_sync_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_din_sync (
        .clk(clk), .reset(reset), .pin(adc_din),
        .sync(din_sync_s), .rise(din_rise_s), .fall(din_fall_s)
    );

    assign unused_s = ^{cs_sync_s, sclk_sync_s, sclk_rise_s, din_rise_s, din_fall_s};

    state_e                  state_r, state_nxt_s;
    logic [FRAME_BITS-1:0]   tx_r, tx_nxt_s;
    logic [FRAME_BITS-1:0]   rx_r, rx_nxt_s, rx_shift_s;
    logic [CNT_BITS-1:0]     bit_cnt_r, bit_cnt_nxt_s;
    logic                    dout_r, dout_nxt_s;
    logic                    oe_r, oe_nxt_s;
    logic [ADDR_BITS-1:0]    cur_addr_r, cur_addr_nxt_s;
    logic [DATA_BITS-1:0]    ctrl_word_r, ctrl_word_nxt_s;
    logic                    ctrl_valid_r, ctrl_valid_nxt_s;
    logic                    frame_err_r, frame_err_nxt_s;
    logic [DATA_BITS-1:0]    sel_data_s;
    logic [FRAME_BITS-1:0]   tx_frame_s;

    // Channel mux; addresses with no channel behind them read as zero
    always_comb begin
        sel_data_s = {DATA_BITS{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            sel_data_s = sel_data_s |
                ((cur_addr_r == ADDR_BITS'(i)) ? ch_data[i*DATA_BITS +: DATA_BITS]
                                               : {DATA_BITS{1'b0}});
        end
        tx_frame_s = build_frame(cur_addr_r, sel_data_s);
    end

    // Next-state and datapath decode for the frame sequencer
    always_comb begin
        state_nxt_s      = state_r;
        tx_nxt_s         = tx_r;
        rx_nxt_s         = rx_r;
        bit_cnt_nxt_s    = bit_cnt_r;
        dout_nxt_s       = dout_r;
        oe_nxt_s         = oe_r;
        cur_addr_nxt_s   = cur_addr_r;
        ctrl_word_nxt_s  = ctrl_word_r;
        ctrl_valid_nxt_s = 1'b0;
        frame_err_nxt_s  = 1'b0;
        rx_shift_s       = {rx_r[FRAME_BITS-2:0], din_sync_s};

        case (state_r)
            ST_IDLE: begin
                dout_nxt_s = 1'b0;
                oe_nxt_s   = 1'b0;
                if (cs_fall_s) begin
                    tx_nxt_s      = tx_frame_s;
                    rx_nxt_s      = {FRAME_BITS{1'b0}};
                    bit_cnt_nxt_s = {CNT_BITS{1'b0}};
                    dout_nxt_s    = tx_frame_s[FRAME_BITS-1];
                    oe_nxt_s      = 1'b1;
                    state_nxt_s   = ST_SHIFT;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // A 16th fall coinciding with CS# rising still completes the frame
                if (sclk_fall_s && (bit_cnt_r == CNT_BITS'(FRAME_BITS - 1))) begin
                    rx_nxt_s      = rx_shift_s;
                    bit_cnt_nxt_s = bit_cnt_r + 5'd1;
                    tx_nxt_s      = {tx_r[FRAME_BITS-2:0], 1'b0};
                    dout_nxt_s    = 1'b0;
                    if (rx_shift_s[WRITE_BIT]) begin
                        ctrl_word_nxt_s  = rx_shift_s[FRAME_BITS-1:CTRL_LSB];
                        cur_addr_nxt_s   = rx_shift_s[ADD_HI:ADD_LO];
                        ctrl_valid_nxt_s = 1'b1;
                    end else begin
                        ctrl_valid_nxt_s = 1'b0;
                    end
                    if (cs_rise_s) begin
                        state_nxt_s = ST_IDLE;
                        oe_nxt_s    = 1'b0;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else if (cs_rise_s) begin
                    state_nxt_s     = ST_IDLE;
                    oe_nxt_s        = 1'b0;
                    dout_nxt_s      = 1'b0;
                    frame_err_nxt_s = 1'b1;
                end else if (sclk_fall_s) begin
                    rx_nxt_s      = rx_shift_s;
                    bit_cnt_nxt_s = bit_cnt_r + 5'd1;
                    tx_nxt_s      = {tx_r[FRAME_BITS-2:0], 1'b0};
                    dout_nxt_s    = tx_r[FRAME_BITS-2];
                end else begin
                    state_nxt_s   = ST_SHIFT;
                end
            end
            ST_DONE: begin
                dout_nxt_s = 1'b0;
                if (cs_rise_s) begin
                    state_nxt_s = ST_IDLE;
                    oe_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                dout_nxt_s  = 1'b0;
                oe_nxt_s    = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            tx_r         <= {FRAME_BITS{1'b0}};
            rx_r         <= {FRAME_BITS{1'b0}};
            bit_cnt_r    <= {CNT_BITS{1'b0}};
            dout_r       <= 1'b0;
            oe_r         <= 1'b0;
            cur_addr_r   <= {ADDR_BITS{1'b0}};
            ctrl_word_r  <= {DATA_BITS{1'b0}};
            ctrl_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            tx_r         <= tx_nxt_s;
            rx_r         <= rx_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            dout_r       <= dout_nxt_s;
            oe_r         <= oe_nxt_s;
            cur_addr_r   <= cur_addr_nxt_s;
            ctrl_word_r  <= ctrl_word_nxt_s;
            ctrl_valid_r <= ctrl_valid_nxt_s;
            frame_err_r  <= frame_err_nxt_s;
        end
    end

    assign adc_dout    = dout_r;
    assign adc_dout_oe = oe_r;
    assign cur_addr    = cur_addr_r;
    assign ctrl_word   = ctrl_word_r;
    assign ctrl_valid  = ctrl_valid_r;
    assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench: SPI master model at 2.5 MHz with a scoreboard of expected DOUT frames.
module tb_adc_spi_responder;

    localparam int NUM_CH = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   adc_cs_n;
    logic                   adc_sclk;
    logic                   adc_din;
    logic [12*NUM_CH-1:0]   ch_data;
    logic                   adc_dout;
    logic                   adc_dout_oe;
    logic [2:0]             cur_addr;
    logic [11:0]            ctrl_word;
    logic                   ctrl_valid;
    logic                   frame_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cv_cnt  = 0;
    int          err_cnt = 0;
    logic [15:0] sb_q[$];
    logic [2:0]  exp_addr;
    logic [11:0] exp_ctrl;

    always #10 clk = ~clk;

    adc_spi_responder #(.SYNC_STAGES(2), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .reset(reset), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
        .adc_din(adc_din), .ch_data(ch_data), .adc_dout(adc_dout),
        .adc_dout_oe(adc_dout_oe), .cur_addr(cur_addr), .ctrl_word(ctrl_word),
        .ctrl_valid(ctrl_valid), .frame_err(frame_err)
    );

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (ctrl_valid) cv_cnt <= cv_cnt + 1;
        if (frame_err)  err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ch_of(input logic [2:0] a);
        return ch_data[int'(a)*12 +: 12];
    endfunction

    // One master frame: 'falls' SCLK falls, optional reset / ch0 change at a given fall index
    task automatic run_frame(input logic [15:0] din, input int falls,
                             input int rst_after, input int chg_after);
        logic [15:0] cap, exp_w, mask;
        int          cv0, err0;
        bit          did_rst;
        bit          done_ok;
        cap     = 16'h0000;
        cv0     = cv_cnt;
        err0    = err_cnt;
        did_rst = 1'b0;
        if (rst_after < 0) sb_q.push_back({1'b0, exp_addr, ch_of(exp_addr)});
        adc_cs_n = 1'b0;
        #400;
        chk("oe_on", 32'(adc_dout_oe), 32'd1);
        for (int k = 0; k < falls; k++) begin
            if (k == rst_after) begin
                reset = 1'b1;
                #100;
                reset    = 1'b0;
                did_rst  = 1'b1;
                exp_addr = 3'd0;
                exp_ctrl = 12'h000;
            end
            if (k == chg_after) ch_data[11:0] = 12'hFFF;
            adc_din = (k < 16) ? din[15-k] : 1'b0;
            #200;
            if (did_rst) begin
                chk("rst_dout", 32'(adc_dout), 32'd0);
                chk("rst_oe", 32'(adc_dout_oe), 32'd0);
            end else if (k < 16) begin
                cap[15-k] = adc_dout;
            end else begin
                chk("tail_dout", 32'(adc_dout), 32'd0);
            end
            adc_sclk = 1'b0;
            #200;
            adc_sclk = 1'b1;
        end
        #200;
        adc_cs_n = 1'b1;
        #400;
        chk("oe_off", 32'(adc_dout_oe), 32'd0);
        done_ok = !did_rst && (falls >= 16) && din[15];
        if (!did_rst) begin
            if (done_ok) begin
                exp_addr = din[12:10];
                exp_ctrl = din[15:4];
            end
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                exp_w = sb_q.pop_front();
                mask  = (falls >= 16) ? 16'hFFFF : ~(16'hFFFF >> falls);
                chk("dout_word", 32'(cap & mask), 32'(exp_w & mask));
            end
        end
        chk("ctrl_valid_cnt", 32'(cv_cnt - cv0), done_ok ? 32'd1 : 32'd0);
        chk("frame_err_cnt", 32'(err_cnt - err0),
            (!did_rst && falls < 16) ? 32'd1 : 32'd0);
        chk("cur_addr", 32'(cur_addr), 32'(exp_addr));
        chk("ctrl_word", 32'(ctrl_word), 32'(exp_ctrl));
    endtask

    initial begin
        reset    = 1'b1;
        adc_cs_n = 1'b1;
        adc_sclk = 1'b1;
        adc_din  = 1'b0;
        exp_addr = 3'd0;
        exp_ctrl = 12'h000;
        for (int n = 0; n < NUM_CH; n++) ch_data[n*12 +: 12] = 12'(n * 12'h111);
        ch_data[0*12 +: 12] = 12'hABC;
        ch_data[3*12 +: 12] = 12'h5A5;
        ch_data[5*12 +: 12] = 12'h777;
        #100;
        reset = 1'b0;

        chk("rst_dout", 32'(adc_dout), 32'd0);
        chk("rst_oe", 32'(adc_dout_oe), 32'd0);
        chk("rst_cur_addr", 32'(cur_addr), 32'd0);
        chk("rst_ctrl_word", 32'(ctrl_word), 32'd0);
        chk("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        #200;

        run_frame(16'h0000, 16, -1, -1);   // read ch0 = 0x0ABC
        run_frame(16'h8C00, 16, -1, -1);   // write ADD=3
        run_frame(16'h0000, 16, -1, -1);   // returns 0x35A5
        run_frame(16'h9400, 9,  -1, -1);   // aborted write of ADD=5
        run_frame(16'h0000, 16, -1, -1);   // still channel 3
        run_frame(16'h8000, 20, -1, -1);   // overlong, switches back to ch0
        run_frame(16'h8C00, 16, -1, -1);   // back to ch3 before reset
        run_frame(16'h9400, 16, 6,  -1);   // reset after 6 falls
        run_frame(16'h0000, 16, -1, -1);   // normal frame after reset: ch0
        ch_data[11:0] = 12'h123;
        #200;
        run_frame(16'h0000, 16, -1, 8);    // ch0 changes mid-frame, still 0x0123
        run_frame(16'h0000, 16, -1, -1);   // now 0x0FFF

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
